// File: rtl/cb_config_loader_if.sv
// ---------------------------------------------------------------------------
// cb_config_loader_if
// Word stream carrying a connection-block configuration bitstream into the
// loader. A word transfers on any rising edge where cfg_valid && cfg_ready.
//   cfg_valid  source -> loader   word on cfg_data is valid
//   cfg_ready  loader -> source   loader accepts a word this cycle
//   cfg_data   source -> loader   configuration word (DATA_W bits)
// Modports: master (bitstream source), slave (loader).
// ---------------------------------------------------------------------------
interface cb_config_loader_if #(
    parameter int DATA_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/cb_config_loader.sv
// ---------------------------------------------------------------------------
// cb_config_loader
// Assembles a configuration bitstream into a shadow register, checks an XOR
// parity word, and only then commits the result to the connection block's
// switch-control vector. The switches never see a partial configuration.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   cfg_start  pulse: begin or restart a load
//   cfg_clear  pulse: open all switches (highest priority)
//   cfg        word stream (slave side: cfg_valid, cfg_data in, cfg_ready out)
//   cfg_busy   high while loading or waiting for the parity word
//   cfg_done   one-cycle pulse after a successful commit
//   cfg_err    one-cycle pulse after a parity mismatch
//   c_loaded   c_out holds a committed, parity-checked configuration
//   c_out      switch-control vector (CFG_W bits)
// The interface instance must be built with the same DATA_W as this module.
// ---------------------------------------------------------------------------
module cb_config_loader #(
    parameter int CFG_W  = 248,
    parameter int DATA_W = 8,
    parameter int NWORDS = (CFG_W + DATA_W - 1) / DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_clear,
    cb_config_loader_if.slave  cfg,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic               c_loaded,
    output logic [CFG_W-1:0]   c_out
);
    localparam int CNT_W = $clog2(NWORDS + 1);
    localparam int SH_W  = NWORDS * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [SH_W-1:0]   shadow;
    logic              xfer;
    logic              last_word;
    logic              load_en;
    logic              check_en;
    logic              parity_ok;

    // Ready depends on state only, never on cfg_valid.
    assign cfg.cfg_ready = (state != IDLE);
    assign cfg_busy      = (state != IDLE);
    assign xfer          = cfg.cfg_valid && (state != IDLE);
    assign last_word     = (cnt == CNT_W'(NWORDS - 1));
    assign parity_ok     = (cfg.cfg_data == acc);

    // Clear beats start, start beats any transfer in the same cycle.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        check_en  = 1'b0;
        if (cfg_clear) begin
            state_nxt = IDLE;
        end else if (cfg_start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        load_en = 1'b1;
                        if (last_word) begin
                            state_nxt = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        check_en  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            c_out    <= '0;
            c_loaded <= 1'b0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (cfg_clear) begin
                c_out    <= '0;
                c_loaded <= 1'b0;
            end else if (cfg_start) begin
                cnt <= '0;
                acc <= '0;
            end else if (load_en) begin
                // Padding bits of the last word still feed the parity.
                acc <= acc ^ cfg.cfg_data;
                cnt <= cnt + CNT_W'(1);
            end else if (check_en) begin
                if (parity_ok) begin
                    c_out    <= shadow[CFG_W-1:0];
                    c_loaded <= 1'b1;
                    cfg_done <= 1'b1;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end
        end
    end

    // Shadow holds data only and is deliberately left unreset; bits above
    // CFG_W in the last word land here but are never committed.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (cnt == CNT_W'(k)) begin
                    shadow[k*DATA_W +: DATA_W] <= cfg.cfg_data;
                end
            end
        end
    end
endmodule

// File: doc/cb_config_loader.md
# cb_config_loader

Configuration sequencer for the routing connection block. It receives a configuration bitstream as a stream of words over a valid/ready handshake and assembles them into a shadow register. It checks an XOR parity word, then commits the result atomically to the connection block's switch-control vector `c`. Switches never see a partially loaded configuration, so transmission gates cannot form transient driver conflicts on the single/double wires during reprogramming.

## Interface
- `CFG_W`, default 248: width of the switch-control vector. This is the full `c` width for the default connection block geometry.
- `DATA_W`, default 8: width of one configuration word.
- `NWORDS`, default `(CFG_W+DATA_W-1)/DATA_W`: number of data words per bitstream. This is a derived parameter; do not override it.

Ports (clock and reset first):
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `cfg_start`  input  1  single-cycle pulse that begins (or restarts) a load.
- `cfg_clear`  input  1  single-cycle pulse that zeroes the committed configuration (all switches open).
- `cfg_valid`  input  1  configuration word valid.
- `cfg_ready`  output  1  loader accepts a word.
- `cfg_data`  input  DATA_W  configuration word.
- `cfg_busy`  output  1  high in LOAD or CHECK.
- `cfg_done`  output  1  one-cycle pulse after a successful commit.
- `cfg_err`  output  1  one-cycle pulse after a parity mismatch.
- `c_loaded`  output  1  `c_out` holds a committed, parity-checked configuration.
- `c_out`  output  CFG_W  switch-control vector driving the connection block `c`.

## Operation
- States: IDLE, LOAD, CHECK.
- Handshake: a word transfers on any edge where `cfg_valid && cfg_ready`.
  - `cfg_ready` = 1 exactly in LOAD or CHECK. It is combinational from state only, with no dependence on `cfg_valid`.
- IDLE, when `cfg_start` = 1: go to LOAD. Word counter ← 0, parity accumulator ← 0. The shadow register is not cleared.
- LOAD, on each transfer:
  - Write word k into shadow bits [k*DATA_W +: DATA_W].
  - Accumulator ^= `cfg_data`.
  - Counter++.
  - On the transfer of word NWORDS-1, go to CHECK.
- Last-word padding: bits of word NWORDS-1 at or above CFG_W are discarded from the shadow but are included in parity.
- CHECK, on a transfer (the parity word):
  - If `cfg_data` == accumulator: `c_out` ← shadow[CFG_W-1:0], `c_loaded` ← 1, `cfg_done` pulses.
  - Otherwise: `c_out` and `c_loaded` are unchanged, and `cfg_err` pulses.
  - Both cases go to IDLE.
- `cfg_start` in LOAD or CHECK: restart. Go to LOAD with counter and accumulator zeroed. Any transfer in that same cycle is discarded.
- `cfg_clear` has the highest priority in any state:
  - `c_out` ← 0, `c_loaded` ← 0, state ← IDLE.
  - A transfer or `cfg_start` in the same cycle is ignored.
  - No `cfg_done` or `cfg_err` pulse.
- `c_out` changes only on a successful commit, on `cfg_clear`, or on reset. It is stable throughout LOAD and CHECK.
- The counter width is `$clog2(NWORDS+1)`. The counter never exceeds NWORDS-1 in LOAD.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State IDLE, `c_out` = 0, `c_loaded` = 0, `cfg_done` = 0, `cfg_err` = 0.
  - Counter and accumulator = 0.
  - `cfg_ready` = 0, `cfg_busy` = 0.
  - Reset mid-load discards the partial load.
- Start latency: `cfg_start` at edge N puts the block in LOAD after edge N, so `cfg_ready` = 1 in cycle N+1. The earliest first word transfers at edge N+1.
- Throughput: one word per cycle with no bubbles. A back-to-back load takes NWORDS+1 transfer cycles.
- Commit: `c_out` and `c_loaded` update at the edge that accepts the parity word.
  - `cfg_done` or `cfg_err` is registered and is high for exactly the following cycle.
  - `cfg_busy` = 0 in that same cycle.
- A `cfg_start` in the cycle where `cfg_done` is high is legal and begins a new load.
- Stalls: `cfg_valid` = 0 in LOAD or CHECK holds all state indefinitely. There is no timeout.
- In IDLE, `cfg_valid` is ignored and no word is consumed.

## Test plan
All scenarios use CFG_W=20, DATA_W=8, so NWORDS=3.

1. Reset, then start; words 0x5A, 0x3C, 0x0F; parity 0x69. Required: `c_out` = 0xF3C5A, `c_loaded` = 1, one `cfg_done` pulse, `cfg_err` never high.
2. Same stream with parity 0x68 after a prior commit of 0xF3C5A. Required: one `cfg_err` pulse, `c_out` remains 0xF3C5A, `c_loaded` remains 1.
3. Start, then words 0xFF, 0xFF, then `cfg_start` again; then 0x01, 0x02, 0xF3, parity 0xF0. Required: `c_out` = 0x30201, a single `cfg_done`, and no effect from the aborted words.
4. With `cfg_valid` toggled randomly during the scenario 1 stream, assert `c_out` stays at its old value (0) in every cycle until the parity edge. Required: final `c_out` is 0xF3C5A.
5. `cfg_clear` asserted together with a valid parity word in CHECK. Required: `c_out` = 0, `c_loaded` = 0, IDLE, no `cfg_done` or `cfg_err` pulse.
6. `rst_n` = 0 after word 1 of a load. Required: all outputs 0 on the next cycle, and a subsequent full load commits normally.
